// File: rtl/bsg_manycore_barrier_ctrl.sv
// Per-tile barrier controller: holds the barrier configuration, runs the local
// phase toggle on join, and waits for the network to echo the phase back.
module bsg_manycore_barrier_ctrl
  #(parameter int barrier_dirs_p  = 7
   ,parameter int timeout_width_p = 16
   ,parameter int timeout_p       = 4096
   ,localparam int barrier_lg_dirs_lp = ((barrier_dirs_p + 1) == 1) ? 1 : $clog2(barrier_dirs_p + 1)
   )
  (input  logic                          clk_i
  ,input  logic                          reset_n_i

  ,input  logic                          cfg_v_i
  ,input  logic [barrier_dirs_p-1:0]     cfg_src_mask_i
  ,input  logic [barrier_lg_dirs_lp-1:0] cfg_dest_i
  ,output logic                          cfg_ready_o

  ,input  logic                          join_v_i
  ,output logic                          join_ready_o

  ,input  logic                          barrier_data_i
  ,output logic                          barrier_data_o

  ,output logic [barrier_dirs_p-1:0]     src_r_o
  ,output logic [barrier_lg_dirs_lp-1:0] dest_r_o
  ,output logic                          done_o
  ,output logic                          error_o
  );

  typedef enum logic [1:0] {IDLE, READY, WAIT} state_e;

  // Counter value on the last permitted wait cycle; unused when timeout_p == 0.
  localparam logic [timeout_width_p-1:0] timeout_last_lp = timeout_width_p'(timeout_p - 1);

  state_e                        state_reg, state_next;
  logic                          phase_reg, phase_next;
  logic [barrier_dirs_p-1:0]     src_reg, src_next;
  logic [barrier_lg_dirs_lp-1:0] dest_reg, dest_next;
  logic [timeout_width_p-1:0]    count_reg, count_next;
  logic                          error_reg, error_next;
  logic                          done_reg, done_next;

  logic cfg_hs, join_hs, match, timeout_hit, count_max;

  assign cfg_ready_o  = (state_reg != WAIT);
  assign join_ready_o = (state_reg == READY);
  assign cfg_hs       = cfg_v_i & cfg_ready_o;
  assign join_hs      = join_v_i & join_ready_o;

  // The network has completed once it reflects our phase back on the P port.
  assign match        = (barrier_data_i == phase_reg);
  assign count_max    = &count_reg;
  assign timeout_hit  = (timeout_p != 0) && (count_reg == timeout_last_lp);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    src_next   = src_reg;
    dest_next  = dest_reg;
    count_next = count_reg;
    error_next = error_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE:    if (cfg_hs) state_next = READY;
      READY:   if (join_hs) state_next = WAIT;
      WAIT: begin
        if (match) begin
          state_next = READY;
          done_next  = 1'b1;
        end else begin
          if (!count_max) count_next = count_reg + 1'b1;
          if (timeout_hit) error_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // cfg and join may land on the same READY edge; both take effect together.
    if (cfg_hs) begin
      src_next  = cfg_src_mask_i;
      dest_next = cfg_dest_i;
    end
    if (join_hs) begin
      phase_next = ~phase_reg;
      count_next = '0;
      error_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      phase_reg <= 1'b0;
      src_reg   <= '0;
      dest_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      src_reg   <= src_next;
      dest_reg  <= dest_next;
      count_reg <= count_next;
      error_reg <= error_next;
      done_reg  <= done_next;
    end
  end

  assign barrier_data_o = phase_reg;
  assign src_r_o        = src_reg;
  assign dest_r_o       = dest_reg;
  assign done_o         = done_reg;
  assign error_o        = error_reg;

endmodule

// File: doc/bsg_manycore_barrier_ctrl.md
BSG_MANYCORE_BARRIER_CTRL -- requirements
Module: bsg_manycore_barrier_ctrl

Interface
REQ-001 SHALL have parameter barrier_dirs_p, default 7: number of barrier directions (bit 0 = P, 1-4 = W/E/N/S, 5-6 = ruche W/E).
REQ-002 SHALL have localparam barrier_lg_dirs_lp = BSG_SAFE_CLOG2(barrier_dirs_p+1): width of the destination select.
REQ-003 SHALL have parameter timeout_width_p, default 16: width of the wait-cycle counter.
REQ-004 SHALL have parameter timeout_p, default 4096: wait-cycle limit; value 0 disables the timeout.
REQ-005 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset_n_i  input  1  synchronous, active-low reset.
REQ-007 cfg_v_i  input  1  configuration valid.
REQ-008 cfg_src_mask_i  input  barrier_dirs_p  directions whose inputs join the barrier.
REQ-009 cfg_dest_i  input  barrier_lg_dirs_lp  direction that receives the barrier output.
REQ-010 cfg_ready_o  output  1  configuration accepted this cycle if cfg_v_i=1.
REQ-011 join_v_i  input  1  core arrives at the barrier.
REQ-012 join_ready_o  output  1  join accepted this cycle if join_v_i=1.
REQ-013 barrier_data_i  input  1  P-port output of the barrier network (completion phase).
REQ-014 barrier_data_o  output  1  P-port input to the barrier network (local phase).
REQ-015 src_r_o  output  barrier_dirs_p  registered source mask to the barrier.
REQ-016 dest_r_o  output  barrier_lg_dirs_lp  registered destination select to the barrier.
REQ-017 done_o  output  1  one-cycle completion pulse.
REQ-018 error_o  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE (unconfigured), READY and WAIT.
REQ-020 IDLE -> READY on cfg handshake; READY -> WAIT on join handshake; WAIT -> READY when barrier_data_i == phase_r.
REQ-021 cfg_ready_o SHALL equal (state != WAIT): no reconfiguration mid-barrier.
REQ-022 join_ready_o SHALL equal (state == READY); join_v_i in IDLE or WAIT SHALL be held off, not dropped, and SHALL cause no state change.
REQ-023 On a cfg handshake, src_r_o and dest_r_o SHALL take cfg_src_mask_i and cfg_dest_i on the next edge.
REQ-024 On a join handshake, phase_r SHALL toggle, barrier_data_o (= phase_r) SHALL change on the next edge, the wait counter SHALL clear to 0 and error_o SHALL clear.
REQ-025 Simultaneous cfg and join handshakes in READY SHALL both be accepted; the new configuration and the toggled phase SHALL appear on the same edge.
REQ-026 In WAIT, barrier_data_i is compared with phase_r every cycle.
REQ-027 On a match: the state SHALL return to READY on the next edge and done_o SHALL be 1 for exactly that following cycle.
REQ-028 Minimum latency from join handshake to done_o SHALL be 2 cycles when barrier_data_i follows the phase combinationally.
REQ-029 The wait counter SHALL increment once per WAIT cycle without a match and saturate at its all-ones value (no wrap).
REQ-030 If timeout_p != 0 and the counter reaches timeout_p-1 without a match, error_o SHALL set on the next edge.
REQ-031 After the timeout, the block SHALL remain in WAIT; error_o SHALL stay set until the next join handshake or reset.
REQ-032 A match in the same cycle the timeout is reached SHALL complete normally and SHALL NOT set error_o.
REQ-033 barrier_data_i changes outside WAIT SHALL be ignored.

Reset
REQ-034 While reset_n_i = 0 at a clock edge: state IDLE, phase_r 0, src_r_o 0, dest_r_o 0, barrier_data_o 0, done_o 0, error_o 0, counter 0.
REQ-035 Reset asserted during WAIT SHALL abandon the barrier and return to IDLE; a fresh cfg handshake is required before the next join.

Verification
REQ-036 After reset, join_v_i=1 with no cfg -> join_ready_o=0 for 10 cycles; barrier_data_o stays 0.
REQ-037 cfg mask 7'b0000011, dest 1, then join; barrier_data_i loops back barrier_data_o -> src_r_o=7'h03, dest_r_o=1, barrier_data_o=1, done_o pulses once 2 cycles after the join.
REQ-038 Two back-to-back barriers -> barrier_data_o goes 1 then 0; done_o gives exactly two one-cycle pulses.
REQ-039 timeout_p=8, barrier_data_i held 0 after join -> error_o=1 after 8 wait cycles; state stays WAIT; later barrier_data_i=1 -> done_o pulses; next join clears error_o.
REQ-040 cfg_v_i held during WAIT -> cfg_ready_o=0 and src_r_o unchanged until done; cfg and join in the same READY cycle -> both accepted on one edge.
REQ-041 reset_n_i=0 mid-WAIT -> all outputs zero next cycle, state IDLE, join_ready_o=0.
